// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle between a binary source and the BCD display path.
// The master issues start/bin_in; the slave returns busy/done/ovf/bcd_out.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             done;
   logic             ovf;
   logic [15:0]      bcd_out;

   modport master (
      output start,
      output bin_in,
      input  busy,
      input  done,
      input  ovf,
      input  bcd_out
   );

   modport slave (
      input  start,
      input  bin_in,
      output busy,
      output done,
      output ovf,
      output bcd_out
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock: done BIN_W edges after start.
// No backpressure: start is ignored while busy; bcd_out/ovf change only on the done edge.
module bin_to_bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   bin_to_bcd_seq_if.slave  bus
);
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [3:0] LAST_CNT = 4'(BIN_W - 1);

   state_t           state_q, state_d;
   logic [BIN_W-1:0] bin_q,   bin_d;
   logic [19:0]      acc_q,   acc_d;
   logic [3:0]       cnt_q,   cnt_d;
   logic             done_q,  done_d;
   logic             ovf_q,   ovf_d;
   logic [15:0]      bcd_q,   bcd_d;

   logic [19:0]      adj;
   logic [20:0]      shl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      adj = '0;
      for (int i = 0; i < 5; i++) begin
         adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                   : acc_q[4*i +: 4];
      end
      // Bit 20 can only be set by a value beyond five digits; fold it into overflow.
      shl = {adj, bin_q[BIN_W-1]};
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               bin_d   = bus.bin_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = shl[19:0];
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               done_d  = 1'b1;
               state_d = IDLE;
               if (|shl[20:16]) begin
                  ovf_d = 1'b1;
                  bcd_d = 16'h9999;
               end else begin
                  ovf_d = 1'b0;
                  bcd_d = shl[15:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy    = (state_q == SHIFT);
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;
   assign bus.bcd_out = bcd_q;
endmodule
